// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared definitions for the 4-requester round-robin mux arbiter.
//   NREQ      number of requesters sharing the mux
//   state_t   arbiter FSM encoding (ST_IDLE = 1'b0, ST_BUSY = 1'b1)
//   onehot4   converts a 2-bit requester index into a one-hot grant vector
package mux4_arb_defs;

    localparam int NREQ = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    function automatic logic [NREQ-1:0] onehot4(input logic [1:0] idx);
        onehot4 = 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/mux4_rr_arbiter_rr_pick4.sv
// Rotating-priority picker for four requesters (purely combinational).
//   req  [3:0]  request vector
//   ptr  [1:0]  index of the most recent winner; the scan starts at ptr+1
//   any         at least one request is set
//   win  [1:0]  first set request in the order ptr+1, ptr+2, ptr+3, ptr (mod 4)
module rr_pick4
    import mux4_arb_defs::*;
(
    input  logic [NREQ-1:0] req,
    input  logic [1:0]      ptr,
    output logic            any,
    output logic [1:0]      win
);

    logic [1:0]        start_s;
    logic [2*NREQ-1:0] dbl_s;
    logic [2*NREQ-1:0] shifted_s;
    logic [NREQ-1:0]   rot_s;
    logic [1:0]        off_s;

    // Rotate the request vector so the highest-priority candidate sits in bit 0;
    // the 2-bit add wraps naturally, so ptr=3 starts the scan at requester 0.
    always_comb begin
        start_s   = ptr + 2'd1;
        dbl_s     = {req, req};
        shifted_s = dbl_s >> start_s;
        rot_s     = shifted_s[NREQ-1:0];
    end

    // Fixed-priority encode on the rotated vector, then map the offset back.
    always_comb begin
        any = |req;
        casez (rot_s)
            4'b???1: off_s = 2'd0;
            4'b??10: off_s = 2'd1;
            4'b?100: off_s = 2'd2;
            4'b1000: off_s = 2'd3;
            default: off_s = 2'd0;
        endcase
        win = start_s + off_s;
    end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter sharing one 4:1 data mux between four packet sources
// and a single valid/ready sink. A grant is held until the packet's last beat,
// withdrawal of the granted request, or MAX_HOLD transferred beats; every
// release is followed by exactly one idle bubble before the next grant.
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   req[3:0], last[3:0]  per-source request and last-beat marker
//   din0..din3           per-source data, selected by sel
//   out_ready            sink accepts a beat when out_valid && out_ready
//   out_valid, out_data  beat towards the sink (combinational from registered sel)
//   gnt[3:0], sel[1:0]   registered one-hot grant and its encoded mux select
//   busy                 high while a grant is active
module mux4_rr_arbiter
    import mux4_arb_defs::*;
#(
    parameter int DW       = 8,
    parameter int MAX_HOLD = 16,
    parameter int CW       = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req,
    input  logic [NREQ-1:0] last,
    input  logic [DW-1:0]   din0,
    input  logic [DW-1:0]   din1,
    input  logic [DW-1:0]   din2,
    input  logic [DW-1:0]   din3,
    input  logic            out_ready,
    output logic            out_valid,
    output logic [DW-1:0]   out_data,
    output logic [NREQ-1:0] gnt,
    output logic [1:0]      sel,
    output logic            busy
);

    // Beat index of the final beat a single grant may carry.
    localparam logic [CW-1:0] CNT_LIMIT = CW'(MAX_HOLD - 1);

    state_t          state_r;
    state_t          state_nxt_s;
    logic [1:0]      ptr_r;
    logic [1:0]      ptr_nxt_s;
    logic [1:0]      sel_r;
    logic [1:0]      sel_nxt_s;
    logic [NREQ-1:0] gnt_r;
    logic [NREQ-1:0] gnt_nxt_s;
    logic [CW-1:0]   cnt_r;
    logic [CW-1:0]   cnt_nxt_s;

    logic            pick_any_s;
    logic [1:0]      pick_win_s;
    logic            busy_s;
    logic            req_sel_s;
    logic            last_sel_s;
    logic            xfer_s;

    rr_pick4 u_pick (
        .req (req),
        .ptr (ptr_r),
        .any (pick_any_s),
        .win (pick_win_s)
    );

    // Status and handshake derived from the registered state and select.
    always_comb begin
        busy_s     = (state_r == ST_BUSY);
        req_sel_s  = req[sel_r];
        last_sel_s = last[sel_r];
        xfer_s     = busy_s && req_sel_s && out_ready;
    end

    // 4:1 data mux on the registered select.
    always_comb begin
        case (sel_r)
            2'd0:    out_data = din0;
            2'd1:    out_data = din1;
            2'd2:    out_data = din2;
            2'd3:    out_data = din3;
            default: out_data = din0;
        endcase
    end

    // Next-state logic: grant from IDLE, count beats and release from BUSY.
    always_comb begin
        state_nxt_s = state_r;
        ptr_nxt_s   = ptr_r;
        sel_nxt_s   = sel_r;
        gnt_nxt_s   = gnt_r;
        cnt_nxt_s   = cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (pick_any_s) begin
                    state_nxt_s = ST_BUSY;
                    sel_nxt_s   = pick_win_s;
                    gnt_nxt_s   = onehot4(pick_win_s);
                    cnt_nxt_s   = {CW{1'b0}};
                end else begin
                    gnt_nxt_s   = {NREQ{1'b0}};
                end
            end
            ST_BUSY: begin
                // Withdrawal, packet end and beat-limit timeout all release the
                // grant; the pointer remembers the owner so it drops to lowest
                // priority in the next scan. sel is kept for the bubble cycle.
                if (!req_sel_s || (xfer_s && last_sel_s) || (xfer_s && (cnt_r == CNT_LIMIT))) begin
                    state_nxt_s = ST_IDLE;
                    gnt_nxt_s   = {NREQ{1'b0}};
                    ptr_nxt_s   = sel_r;
                    cnt_nxt_s   = {CW{1'b0}};
                end else if (xfer_s) begin
                    cnt_nxt_s   = cnt_r + CW'(1);
                end else begin
                    cnt_nxt_s   = cnt_r;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                gnt_nxt_s   = {NREQ{1'b0}};
                cnt_nxt_s   = {CW{1'b0}};
            end
        endcase
    end

    // Arbiter state registers; ptr resets to 3 so requester 0 wins first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            ptr_r   <= 2'd3;
            sel_r   <= 2'd0;
            gnt_r   <= {NREQ{1'b0}};
            cnt_r   <= {CW{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            ptr_r   <= ptr_nxt_s;
            sel_r   <= sel_nxt_s;
            gnt_r   <= gnt_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Output drive from the registered state.
    always_comb begin
        gnt       = gnt_r;
        sel       = sel_r;
        busy      = busy_s;
        out_valid = busy_s && req_sel_s;
    end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Self-checking bench for mux4_rr_arbiter: packet sources with randomized
// lengths, withdrawals and backpressure, compared every cycle against an
// owner/beat-count reference model, plus literal expectations for the
// directed scenarios (reset, rotation order, timeout, stall, withdrawal,
// asynchronous reset mid-packet).
module tb_mux4_rr_arbiter;

    localparam int DW       = 8;
    localparam int MAX_HOLD = 16;
    localparam int CW       = 5;

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b1;
    logic [3:0]    req       = 4'b0000;
    logic [3:0]    last      = 4'b0000;
    logic [DW-1:0] din0      = 8'h00;
    logic [DW-1:0] din1      = 8'h00;
    logic [DW-1:0] din2      = 8'h00;
    logic [DW-1:0] din3      = 8'h00;
    logic          out_ready = 1'b0;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic [3:0]    gnt;
    logic [1:0]    sel;
    logic          busy;

    mux4_rr_arbiter #(.DW(DW), .MAX_HOLD(MAX_HOLD), .CW(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .last      (last),
        .din0      (din0),
        .din1      (din1),
        .din2      (din2),
        .din3      (din3),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .gnt       (gnt),
        .sel       (sel),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Packet sources: rem = beats still to send, wd = temporarily withdrawn.
    int            rem[4];
    bit            wd[4];
    bit            refill = 1'b0;

    // Reference model: owner index (-1 when no grant), rotation pointer,
    // last select value, beats moved in the current grant.
    int m_owner  = -1;
    int m_ptr    = 3;
    int m_sel    = 0;
    int m_beats  = 0;
    int xfer_src = -1;

    // Observations of the DUT, compared against literals in directed tests.
    int grant_log[$];
    int gxf[$];
    int dut_xfers = 0;
    bit prev_busy = 1'b0;
    int cand;
    bit found;

    function automatic int src_data(input int i);
        case (i)
            0:       return int'(din0);
            1:       return int'(din1);
            2:       return int'(din2);
            default: return int'(din3);
        endcase
    endfunction

    task automatic drive();
        for (int i = 0; i < 4; i++) begin
            req[i]  = (rem[i] > 0) && !wd[i];
            last[i] = (rem[i] == 1);
        end
    endtask

    // Advance to just after the next rising edge and update the sources.
    task automatic step();
        @(posedge clk);
        #1;
        if (xfer_src >= 0) rem[xfer_src] = rem[xfer_src] - 1;
        for (int i = 0; i < 4; i++) begin
            if (refill && rem[i] == 0) rem[i] = 2;
        end
        din0 = 8'($urandom);
        din1 = 8'($urandom);
        din2 = 8'($urandom);
        din3 = 8'($urandom);
        drive();
    endtask

    task automatic clear_logs();
        grant_log.delete();
        gxf.delete();
        dut_xfers = 0;
    endtask

    // Per-cycle compare against the model, then advance the model.
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_gnt", int'(gnt), 0);
            chk("rst_sel", int'(sel), 0);
            chk("rst_busy", int'(busy), 0);
            chk("rst_valid", int'(out_valid), 0);
            m_owner   = -1;
            m_ptr     = 3;
            m_sel     = 0;
            m_beats   = 0;
            xfer_src  = -1;
            prev_busy = 1'b0;
        end else begin
            chk("gnt", int'(gnt), (m_owner < 0) ? 0 : (1 << m_owner));
            chk("busy", int'(busy), (m_owner >= 0) ? 1 : 0);
            chk("sel", int'(sel), m_sel);
            chk("out_valid", int'(out_valid), (m_owner >= 0 && req[m_owner]) ? 1 : 0);
            if (m_owner >= 0 && req[m_owner]) chk("out_data", int'(out_data), src_data(m_owner));

            if (busy && !prev_busy) begin
                grant_log.push_back(int'(sel));
                gxf.push_back(0);
            end
            if (out_valid && out_ready) begin
                dut_xfers++;
                if (gxf.size() > 0) gxf[gxf.size()-1] = gxf[gxf.size()-1] + 1;
            end
            prev_busy = busy;

            xfer_src = -1;
            if (m_owner < 0) begin
                found = 1'b0;
                for (int k = 1; k <= 4; k++) begin
                    cand = (m_ptr + k) % 4;
                    if (!found && req[cand]) begin
                        found   = 1'b1;
                        m_owner = cand;
                        m_sel   = cand;
                        m_beats = 0;
                    end
                end
            end else if (!req[m_owner]) begin
                m_ptr   = m_owner;
                m_owner = -1;
            end else if (out_ready) begin
                xfer_src = m_owner;
                m_beats++;
                if (last[m_owner] || m_beats == MAX_HOLD) begin
                    m_ptr   = m_owner;
                    m_owner = -1;
                end
            end
        end
    end

    initial begin
        int exp_order[5];
        exp_order = '{0, 1, 2, 3, 0};
        for (int i = 0; i < 4; i++) begin
            rem[i] = 0;
            wd[i]  = 1'b0;
        end

        // Reset with all four sources requesting 2-beat packets.
        #1 rst_n = 1'b0;
        for (int i = 0; i < 4; i++) rem[i] = 2;
        out_ready = 1'b1;
        refill    = 1'b1;
        drive();
        step();
        step();
        rst_n = 1'b1;
        clear_logs();
        step();
        chk("t1_gnt", int'(gnt), 1);
        chk("t1_sel", int'(sel), 0);
        chk("t1_busy", int'(busy), 1);

        // Rotation: grants 0,1,2,3,0 with two beats and one bubble each.
        repeat (14) step();
        chk("t2_ngrants", grant_log.size(), 5);
        for (int k = 0; k < 5; k++) begin
            if (k < grant_log.size()) chk("t2_order", grant_log[k], exp_order[k]);
        end
        chk("t2_xfers", dut_xfers, 10);
        refill = 1'b0;
        repeat (20) step();

        // 20-beat packet from source 2: timeout after 16 beats, then 4 more.
        clear_logs();
        rem[2] = 20;
        drive();
        repeat (30) step();
        chk("t3_ngrants", gxf.size(), 2);
        if (gxf.size() == 2) begin
            chk("t3_first", gxf[0], 16);
            chk("t3_second", gxf[1], 4);
            chk("t3_regrant", grant_log[1], 2);
        end
        chk("t3_xfers", dut_xfers, 20);

        // Backpressure on source 1 for 30 clocks: grant held, no beats counted.
        clear_logs();
        out_ready = 1'b0;
        rem[1]    = 18;
        drive();
        step();
        chk("t4_gnt_start", int'(gnt), 2);
        repeat (30) step();
        chk("t4_gnt_held", int'(gnt), 2);
        chk("t4_valid", int'(out_valid), 1);
        chk("t4_no_xfer", dut_xfers, 0);
        out_ready = 1'b1;
        drive();
        repeat (25) step();
        chk("t4_ngrants", gxf.size(), 2);
        if (gxf.size() == 2) begin
            chk("t4_first", gxf[0], 16);
            chk("t4_second", gxf[1], 2);
        end

        // Source 3 withdraws mid-packet while 0, 1, 2 wait: 0 wins next.
        clear_logs();
        rem[3] = 10;
        drive();
        step();
        chk("t5_gnt3", int'(gnt), 8);
        step();
        step();
        rem[0] = 3;
        rem[1] = 3;
        rem[2] = 3;
        wd[3]  = 1'b1;
        drive();
        #1;
        chk("t5_valid_drop", int'(out_valid), 0);
        chk("t5_still_busy", int'(busy), 1);
        step();
        chk("t5_idle", int'(busy), 0);
        chk("t5_gnt_zero", int'(gnt), 0);
        step();
        chk("t5_next_src0", int'(gnt), 1);
        wd[3] = 1'b0;
        drive();
        repeat (40) step();

        // Randomized packets, withdrawals and backpressure.
        repeat (3000) begin
            step();
            for (int i = 0; i < 4; i++) begin
                if (rem[i] == 0 && $urandom_range(3) == 0) rem[i] = $urandom_range(20, 1);
                if (wd[i]) begin
                    if ($urandom_range(1) == 0) wd[i] = 1'b0;
                end else if ($urandom_range(15) == 0) begin
                    wd[i] = 1'b1;
                end
            end
            out_ready = ($urandom_range(3) != 0);
            drive();
        end

        // Asynchronous reset pulse mid-transfer, then restart at source 0.
        for (int i = 0; i < 4; i++) begin
            wd[i]  = 1'b0;
            rem[i] = 5;
        end
        out_ready = 1'b1;
        drive();
        repeat (3) step();
        #1 rst_n = 1'b0;
        #1;
        chk("t6_gnt", int'(gnt), 0);
        chk("t6_valid", int'(out_valid), 0);
        chk("t6_busy", int'(busy), 0);
        step();
        rst_n = 1'b1;
        step();
        chk("t6_restart", int'(gnt), 1);
        repeat (10) step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
